// File: rtl/acc_adder_pipe.sv
// ---------------------------------------------------------------------------
// acc_adder_pipe
//
// Two-stage accumulating adder used at the tail of a MAC array.
// Each accepted beat carries NUM_IN signed channel products. Depending on
// Mode, a partial sum and a bias are added to them. The wide total is then
// saturated (or wrapped) back to INTERNAL_BITS and optionally passed
// through a ReLU.
//
//   S1 : adder-tree sum of the channels (INTERNAL_BITS+4 wide), plus the
//        captured Psum, Bias and Mode.
//   S2 : final Result and sat_flag, presented downstream.
//
// Handshake (both sides): a beat moves on a rising clk edge where valid and
// ready are both 1. A producer holds valid and its payload steady until that
// edge. in_ready depends on S1/S2 occupancy and on out_ready, and never on
// in_valid. While out_valid=1 and out_ready=0, the output side holds
// Result/sat_flag/out_valid unchanged.
//
// Parameters
//   NUM_IN        channel inputs summed per beat (2..8)
//   DATA_BITS     Bias width
//   INTERNAL_BITS channel, Psum and Result width
//   SAT           1 = clamp Result on overflow, 0 = keep low bits (wrap)
//
// Ports
//   clk, rst_n   single clock, synchronous active-low reset
//   in_valid     input beat valid          in_ready  block can take a beat
//   Data_in      packed channels, channel k at [k*INTERNAL_BITS +: INTERNAL_BITS]
//   Psum         signed partial sum        Bias      signed bias
//   Mode         00 sum, 01 +Psum, 10 +Psum+Bias, 11 +Psum+Bias then ReLU
//   out_valid    Result valid              out_ready downstream accepts
//   Result       signed result (0 whenever out_valid=0)
//   sat_flag     Result was clamped (0 whenever out_valid=0)
// ---------------------------------------------------------------------------
module acc_adder_pipe #(
  parameter int NUM_IN        = 3,
  parameter int DATA_BITS     = 8,
  parameter int INTERNAL_BITS = 32,
  parameter int SAT           = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_IN*INTERNAL_BITS-1:0] Data_in,
  input  logic [INTERNAL_BITS-1:0]        Psum,
  input  logic [DATA_BITS-1:0]            Bias,
  input  logic [1:0]                      Mode,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [INTERNAL_BITS-1:0]        Result,
  output logic                            sat_flag
);

  // Four guard bits are enough for up to 8 channels + Psum + Bias
  // (10 operands) without the wide sum itself overflowing.
  localparam int GUARD = 4;
  localparam int WIDE  = INTERNAL_BITS + GUARD;

  localparam logic [1:0] MODE_SUM  = 2'b00;
  localparam logic [1:0] MODE_BIAS = 2'b10;
  localparam logic [1:0] MODE_RELU = 2'b11;

  // Clamp limits in Result width.
  localparam logic [INTERNAL_BITS-1:0] RES_MAX = {1'b0, {(INTERNAL_BITS-1){1'b1}}};
  localparam logic [INTERNAL_BITS-1:0] RES_MIN = {1'b1, {(INTERNAL_BITS-1){1'b0}}};

  // -------------------------------------------------------------------------
  // Stage 1 combinational: channel adder tree.
  // Operands are explicitly sign-extended, so plain (unsigned) two's
  // complement addition gives the correct signed wide sum.
  // -------------------------------------------------------------------------
  logic [WIDE-1:0] chan_sum;

  always_comb begin
    chan_sum = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      chan_sum = chan_sum
               + {{GUARD{Data_in[k*INTERNAL_BITS + INTERNAL_BITS-1]}},
                  Data_in[k*INTERNAL_BITS +: INTERNAL_BITS]};
    end
  end

  // -------------------------------------------------------------------------
  // Pipeline registers
  // -------------------------------------------------------------------------
  logic                     s1_valid;
  logic [WIDE-1:0]          s1_sum;
  logic [INTERNAL_BITS-1:0] s1_psum;
  logic [DATA_BITS-1:0]     s1_bias;
  logic [1:0]               s1_mode;

  // S2 is the output register set itself: out_valid, Result, sat_flag.

  // -------------------------------------------------------------------------
  // Stage 2 combinational: mode-dependent operands, saturation, ReLU.
  // -------------------------------------------------------------------------
  logic                     psum_en;
  logic                     bias_en;
  logic                     relu_en;
  logic [WIDE-1:0]          psum_ext;
  logic [WIDE-1:0]          bias_ext;
  logic [WIDE-1:0]          wide_total;
  logic [GUARD:0]           wide_top;
  logic                     overflow;
  logic [INTERNAL_BITS-1:0] sat_res;
  logic                     sat_hit;
  logic [INTERNAL_BITS-1:0] final_res;

  always_comb begin
    psum_en  = (s1_mode != MODE_SUM);
    bias_en  = (s1_mode == MODE_BIAS) || (s1_mode == MODE_RELU);
    relu_en  = (s1_mode == MODE_RELU);

    psum_ext = {{GUARD{s1_psum[INTERNAL_BITS-1]}}, s1_psum};
    bias_ext = {{(WIDE-DATA_BITS){s1_bias[DATA_BITS-1]}}, s1_bias};

    wide_total = s1_sum
               + (psum_en ? psum_ext : '0)
               + (bias_en ? bias_ext : '0);

    // The value fits in INTERNAL_BITS exactly when the guard bits and the
    // Result sign bit are all copies of one another.
    wide_top = wide_total[WIDE-1:INTERNAL_BITS-1];
    overflow = (wide_top != '0) && (wide_top != '1);

    sat_res = wide_total[INTERNAL_BITS-1:0];
    sat_hit = 1'b0;
    if ((SAT != 0) && overflow) begin
      sat_hit = 1'b1;
      // The sign of the wide total tells which rail was crossed.
      sat_res = wide_total[WIDE-1] ? RES_MIN : RES_MAX;
    end

    // ReLU acts on the already clamped/wrapped value. sat_flag still reports
    // a clamp even when ReLU then forces the value to zero.
    final_res = sat_res;
    if (relu_en && sat_res[INTERNAL_BITS-1]) begin
      final_res = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Flow control
  // -------------------------------------------------------------------------
  logic s2_advance;

  // S2 may load when it is empty or its beat is leaving this cycle.
  assign s2_advance = !out_valid || out_ready;
  // S1 may load when it is empty or its beat is moving into S2.
  assign in_ready   = !s1_valid || s2_advance;

  // -------------------------------------------------------------------------
  // Sequential state
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_sum    <= '0;
      s1_psum   <= '0;
      s1_bias   <= '0;
      s1_mode   <= MODE_SUM;
      out_valid <= 1'b0;
      Result    <= '0;
      sat_flag  <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_sum  <= chan_sum;
          s1_psum <= Psum;
          s1_bias <= Bias;
          s1_mode <= Mode;
        end
      end

      if (s2_advance) begin
        out_valid <= s1_valid;
        // An empty S2 shows zeros rather than a stale result.
        Result    <= s1_valid ? final_res : '0;
        sat_flag  <= s1_valid ? sat_hit : 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_acc_adder_pipe.sv
// ---------------------------------------------------------------------------
// tb_acc_adder_pipe
//
// Bench for acc_adder_pipe with NUM_IN=3, DATA_BITS=8, INTERNAL_BITS=32.
// Two instances share all stimulus: dut (SAT=1) and dut_w (SAT=0).
// A table of hand-computed vectors (SAT=1 expectations) is streamed. The
// SAT=0 expectations and random beats come from a 64-bit reference model.
// A monitor pops per-instance expectation queues on each output transfer.
// It also checks held values while stalled and zero outputs while idle.
// ---------------------------------------------------------------------------
module tb_acc_adder_pipe;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  int   cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        in_valid;
  logic        out_ready;
  logic [95:0] data_in;
  logic [31:0] psum;
  logic [7:0]  bias;
  logic [1:0]  mode;

  logic        in_ready,  out_valid,  sat_flag;
  logic [31:0] result;
  logic        in_ready_w, out_valid_w, sat_flag_w;
  logic [31:0] result_w;

  acc_adder_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .Data_in(data_in), .Psum(psum), .Bias(bias), .Mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .Result(result),
    .sat_flag(sat_flag)
  );

  acc_adder_pipe #(.SAT(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .Data_in(data_in), .Psum(psum), .Bias(bias), .Mode(mode),
    .out_valid(out_valid_w), .out_ready(out_ready), .Result(result_w),
    .sat_flag(sat_flag_w)
  );

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  logic        exp_sat_q[$];
  logic [31:0] exp_w_q[$];
  logic        exp_wsat_q[$];

  int n_chk;
  int n_err;
  bit rand_ready;

  typedef struct {
    logic [95:0] d;
    logic [31:0] p;
    logic [7:0]  b;
    logic [1:0]  m;
    logic [31:0] r;  // expected Result, SAT=1
    logic        f;  // expected sat_flag, SAT=1
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact 64-bit sum, then clamp or wrap, then ReLU.
  function automatic logic [32:0] model(input logic [95:0] d, input logic [31:0] p,
                                        input logic [7:0] b, input logic [1:0] m,
                                        input bit sat);
    longint s, lim_hi, lim_lo;
    logic [31:0] r;
    logic f;
    lim_hi = 64'sd2147483647;
    lim_lo = -lim_hi - 1;
    s = 0;
    for (int k = 0; k < 3; k++) s += longint'($signed(d[32*k +: 32]));
    if (m != 2'b00) s += longint'($signed(p));
    if (m[1])       s += longint'($signed(b));
    r = s[31:0];
    f = 1'b0;
    if (sat) begin
      if (s > lim_hi) begin r = 32'h7FFFFFFF; f = 1'b1; end
      else if (s < lim_lo) begin r = 32'h80000000; f = 1'b1; end
    end
    if (m == 2'b11 && r[31]) r = '0;
    return {f, r};
  endfunction

  // ---------------- driver ----------------
  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input vec_t v);
    logic [32:0] wm;
    int n;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    data_in  = v.d;
    psum     = v.p;
    bias     = v.b;
    mode     = v.m;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!(in_ready && in_ready_w) && n < 50) begin
      @(negedge clk);
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      #1;
      n++;
    end
    if (!(in_ready && in_ready_w)) begin
      chk("send_timeout", {32'd0, in_ready}, 33'd1);
    end else begin
      wm = model(v.d, v.p, v.b, v.m, 1'b0);
      exp_q.push_back(v.r);
      exp_sat_q.push_back(v.f);
      exp_w_q.push_back(wm[31:0]);
      exp_wsat_q.push_back(wm[32]);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    vec_t v;
    logic [32:0] sm;
    for (int k = 0; k < 3; k++) begin
      case ($urandom_range(0, 3))
        0: v.d[32*k +: 32] = 32'($urandom_range(0, 2000)) - 32'd1000;
        1: v.d[32*k +: 32] = 32'h7FFFFFFF - 32'($urandom_range(0, 3));
        2: v.d[32*k +: 32] = 32'h80000000 + 32'($urandom_range(0, 3));
        default: v.d[32*k +: 32] = $urandom;
      endcase
    end
    v.p = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 200)) - 32'd100;
    v.b = 8'($urandom_range(0, 255));
    v.m = 2'($urandom_range(0, 3));
    sm  = model(v.d, v.p, v.b, v.m, 1'b1);
    v.r = sm[31:0];
    v.f = sm[32];
    send(v);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, 33'(exp_q.size()), 33'd0);
  endtask

  // ---------------- monitor ----------------
  bit was_stalled;

  always begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      was_stalled = 1'b0;
    end else begin
      if (was_stalled && !out_valid) chk("stall_drop", {32'd0, out_valid}, 33'd1);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", {32'd0, out_valid}, 33'd0);
        end else begin
          chk("result",   {1'b0, result},   {1'b0, exp_q[0]});
          chk("sat_flag", {32'd0, sat_flag}, {32'd0, exp_sat_q[0]});
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(exp_sat_q.pop_front());
          end
        end
      end else begin
        chk("idle_zero", {sat_flag, result}, 33'd0);
      end
      if (out_valid_w) begin
        if (exp_w_q.size() == 0) begin
          chk("unexpected_out_w", {32'd0, out_valid_w}, 33'd0);
        end else begin
          chk("result_wrap", {sat_flag_w, result_w}, {exp_wsat_q[0], exp_w_q[0]});
          if (out_ready) begin
            void'(exp_w_q.pop_front());
            void'(exp_wsat_q.pop_front());
          end
        end
      end else begin
        chk("idle_zero_w", {sat_flag_w, result_w}, 33'd0);
      end
      was_stalled = out_valid && !out_ready;
    end
  end

  // ---------------- test sequence ----------------
  int t0;

  initial begin
    vecs[0]  = '{{32'd10, 32'hFFFFFFFD, 32'd5},           32'd100,        8'hF8, 2'b10, 32'd104,        1'b0};
    vecs[1]  = '{{32'd0, 32'd0, 32'hFFFFFFCE},            32'd10,         8'h00, 2'b11, 32'd0,          1'b0};
    vecs[2]  = '{{32'd0, 32'd0, 32'd7},                   32'd0,          8'h00, 2'b11, 32'd7,          1'b0};
    vecs[3]  = '{{32'd0, 32'd1, 32'h7FFFFFFF},            32'd0,          8'h00, 2'b00, 32'h7FFFFFFF,   1'b1};
    vecs[4]  = '{{32'd1, 32'd2, 32'd3},                   32'd1000,       8'h05, 2'b00, 32'd6,          1'b0};
    vecs[5]  = '{{32'd1, 32'd2, 32'd3},                   32'd1000,       8'h05, 2'b01, 32'd1006,       1'b0};
    vecs[6]  = '{{32'h80000000, 32'h80000000, 32'd0},     32'd0,          8'h00, 2'b00, 32'h80000000,   1'b1};
    vecs[7]  = '{{32'h80000000, 32'hFFFFFFFF, 32'd0},     32'd0,          8'h00, 2'b11, 32'd0,          1'b1};
    vecs[8]  = '{{32'h7FFFFFFF, 32'h7FFFFFFF, 32'd0},     32'd0,          8'h00, 2'b11, 32'h7FFFFFFF,   1'b1};
    vecs[9]  = '{{32'd0, 32'd0, 32'd0},                   32'd0,          8'h7F, 2'b10, 32'd127,        1'b0};
    vecs[10] = '{{32'd0, 32'd0, 32'd0},                   32'hFFFFFFFF,   8'h80, 2'b10, 32'hFFFFFF7F,   1'b0};
    vecs[11] = '{{32'h7FFFFFFF, 32'd0, 32'd0},            32'd1,          8'h00, 2'b01, 32'h7FFFFFFF,   1'b1};
    vecs[12] = '{{32'h7FFFFFFE, 32'd0, 32'd0},            32'd1,          8'h00, 2'b01, 32'h7FFFFFFF,   1'b0};
    vecs[13] = '{{32'h80000000, 32'd0, 32'd0},            32'd0,          8'h00, 2'b00, 32'h80000000,   1'b0};
    vecs[14] = '{{32'd5, 32'hFFFFFFFB, 32'd0},            32'd0,          8'h00, 2'b11, 32'd0,          1'b0};
    vecs[15] = '{{32'h80000000, 32'd0, 32'd0},            32'hFFFFFFFF,   8'h80, 2'b10, 32'h80000000,   1'b1};

    n_chk = 0;
    n_err = 0;
    cyc = 0;
    rand_ready = 1'b0;
    was_stalled = 1'b0;

    // Reset held two cycles with a valid beat on the input.
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    data_in   = {32'd1, 32'd2, 32'd3};
    psum      = 32'd4;
    bias      = 8'd5;
    mode      = 2'b10;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid, out_valid_w}, 33'd0);
    chk("rst_result",    {1'b0, result}, 33'd0);
    chk("rst_sat",       {31'd0, sat_flag, sat_flag_w}, 33'd0);
    chk("rst_result_w",  {1'b0, result_w}, 33'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("in_ready_after_rst", {31'd0, in_ready, in_ready_w}, 33'd3);
    @(negedge clk);

    // Mode 10 latency: output exactly two cycles after acceptance.
    send(vecs[0]);
    #1;
    chk("lat_1cyc_valid", {32'd0, out_valid}, 33'd0);
    @(negedge clk);
    #1;
    chk("lat_2cyc_valid", {32'd0, out_valid}, 33'd1);
    chk("lat_2cyc_result", {1'b0, result}, 33'd104);
    @(negedge clk);

    // Mode 11 back-to-back: one result per cycle.
    send(vecs[1]);
    send(vecs[2]);
    #1;
    chk("b2b_first",  {out_valid, result}, {1'b1, 32'd0});
    @(negedge clk);
    #1;
    chk("b2b_second", {out_valid, result}, {1'b1, 32'd7});
    @(negedge clk);

    // Saturation vs wrap on the same beat.
    send(vecs[3]);
    @(negedge clk);
    #1;
    chk("sat_clamp", {sat_flag, result},     {1'b1, 32'h7FFFFFFF});
    chk("sat_wrap",  {sat_flag_w, result_w}, {1'b0, 32'h80000000});
    @(negedge clk);
    drain("drain_directed");

    // Full table streamed back-to-back: one beat accepted per cycle.
    t0 = cyc;
    for (int i = 0; i < 16; i++) send(vecs[i]);
    chk("throughput_cycles", 33'(cyc - t0), 33'd16);
    drain("drain_table");

    // Random beats under random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) send_rand();
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    drain("drain_random");

    // Backpressure: beats 1..4, out_ready low for three cycles.
    send('{{32'd0, 32'd0, 32'd1}, 32'd0, 8'd0, 2'b00, 32'd1, 1'b0});
    send('{{32'd0, 32'd0, 32'd2}, 32'd0, 8'd0, 2'b00, 32'd2, 1'b0});
    out_ready = 1'b0;
    data_in   = {32'd0, 32'd0, 32'd3};
    mode      = 2'b00;
    in_valid  = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", {32'd0, in_ready}, 33'd0);
      chk("bp_hold",     {out_valid, result}, {1'b1, 32'd1});
      @(negedge clk);
      #1;
    end
    out_ready = 1'b1;
    send('{{32'd0, 32'd0, 32'd3}, 32'd0, 8'd0, 2'b00, 32'd3, 1'b0});
    send('{{32'd0, 32'd0, 32'd4}, 32'd0, 8'd0, 2'b00, 32'd4, 1'b0});
    drain("drain_backpressure");

    // Reset mid-stream with S1 and S2 both full.
    send(vecs[4]);
    send(vecs[5]);
    rst_n = 1'b0;
    exp_q.delete();
    exp_sat_q.delete();
    exp_w_q.delete();
    exp_wsat_q.delete();
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("midrst_out_valid", {31'd0, out_valid, out_valid_w}, 33'd0);
    chk("midrst_result",    {sat_flag, result}, 33'd0);
    rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", {32'd0, in_ready}, 33'd1);
    repeat (6) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1);
  end

endmodule
